// File: rtl/sccb_slave_responder.sv
`default_nettype none
// ============================================================================
// sccb_slave_responder : SCCB/I2C target with a register bank, write strobes
// Revision 1.0
// ============================================================================
module sccb_slave_responder #(
  parameter logic [6:0]  DEV_ID    = 7'h3C,
  parameter int unsigned ADDR_BITS = 8
) (
  input  logic        I_clk,
  input  logic        I_rst,
  input  logic        I_scl,
  input  logic        I_sda,
  output logic        O_sda_oe,
  output logic        O_wr_valid,
  output logic [15:0] O_wr_addr,
  output logic [7:0]  O_wr_data,
  output logic        O_busy
);

  localparam int unsigned c_DEPTH = 1 << ADDR_BITS;

  typedef enum logic [3:0] {
    S_IDLE, S_DEV, S_ACK_DEV, S_ADDR_H, S_ACK_AH, S_ADDR_L, S_ACK_AL,
    S_WDATA, S_ACK_WD, S_RDATA, S_RACK, S_WAIT_STOP
  } state_t;

  logic r_scl_s1, r_scl_s2, r_scl_h;
  logic r_sda_s1, r_sda_s2, r_sda_h;
  logic r_scl_rise, r_scl_fall, r_start, r_stop, r_sda_smp;

  state_t      r_state;
  logic [3:0]  r_bitcnt;
  logic [6:0]  r_shift;
  logic [7:0]  r_addr_h;
  logic [15:0] r_ptr;
  logic        r_rw;
  logic        r_ninth;
  logic        r_mack;
  logic [6:0]  r_rd;
  logic [7:0]  r_mem [0:c_DEPTH-1];

  logic [7:0]  w_byte;
  logic [15:0] w_ptr_nxt;
  logic [7:0]  w_rd_cur;
  logic [7:0]  w_rd_nxt;
  logic        w_mem_we;

  // Flags are registered so a pin transition reaches the FSM after 3 clocks
  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      r_scl_s1   <= 1'b1;
      r_scl_s2   <= 1'b1;
      r_scl_h    <= 1'b1;
      r_sda_s1   <= 1'b1;
      r_sda_s2   <= 1'b1;
      r_sda_h    <= 1'b1;
      r_scl_rise <= 1'b0;
      r_scl_fall <= 1'b0;
      r_start    <= 1'b0;
      r_stop     <= 1'b0;
      r_sda_smp  <= 1'b1;
    end else begin
      r_scl_s1   <= I_scl;
      r_scl_s2   <= r_scl_s1;
      r_scl_h    <= r_scl_s2;
      r_sda_s1   <= I_sda;
      r_sda_s2   <= r_sda_s1;
      r_sda_h    <= r_sda_s2;
      r_scl_rise <= r_scl_s2 & ~r_scl_h;
      r_scl_fall <= ~r_scl_s2 & r_scl_h;
      r_start    <= r_scl_s2 & r_scl_h & ~r_sda_s2 & r_sda_h;
      r_stop     <= r_scl_s2 & r_scl_h & r_sda_s2 & ~r_sda_h;
      r_sda_smp  <= r_sda_s2;
    end
  end

  assign w_byte    = {r_shift, r_sda_smp};
  assign w_ptr_nxt = r_ptr + 16'd1;
  assign w_rd_cur  = r_mem[r_ptr[ADDR_BITS-1:0]];
  assign w_rd_nxt  = r_mem[w_ptr_nxt[ADDR_BITS-1:0]];
  assign w_mem_we  = ~I_rst & ~r_start & ~r_stop & (r_state == S_WDATA) &
                     r_scl_rise & (r_bitcnt == 4'd7);

  // Register bank is deliberately left out of reset
  always_ff @(posedge I_clk) begin
    if (w_mem_we) begin
      r_mem[r_ptr[ADDR_BITS-1:0]] <= w_byte;
    end
  end

  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      r_state    <= S_IDLE;
      r_bitcnt   <= 4'd0;
      r_shift    <= 7'd0;
      r_addr_h   <= 8'd0;
      r_ptr      <= 16'd0;
      r_rw       <= 1'b0;
      r_ninth    <= 1'b0;
      r_mack     <= 1'b1;
      r_rd       <= 7'd0;
      O_sda_oe   <= 1'b0;
      O_wr_valid <= 1'b0;
      O_wr_addr  <= 16'd0;
      O_wr_data  <= 8'd0;
      O_busy     <= 1'b0;
    end else begin
      O_wr_valid <= 1'b0;
      if (r_stop) begin
        r_state  <= S_IDLE;
        O_sda_oe <= 1'b0;
        O_busy   <= 1'b0;
      end else if (r_start) begin
        r_state  <= S_DEV;
        r_bitcnt <= 4'd0;
        O_sda_oe <= 1'b0;
      end else begin
        case (r_state)
          S_DEV, S_ADDR_H, S_ADDR_L, S_WDATA: begin
            if (r_scl_rise) begin
              r_shift  <= w_byte[6:0];
              r_bitcnt <= r_bitcnt + 4'd1;
              if (r_bitcnt == 4'd7) begin
                r_bitcnt <= 4'd0;
                r_ninth  <= 1'b0;
                case (r_state)
                  S_DEV: begin
                    if (w_byte[7:1] == DEV_ID) begin
                      r_rw    <= w_byte[0];
                      O_busy  <= 1'b1;
                      r_state <= S_ACK_DEV;
                    end else begin
                      O_busy  <= 1'b0;
                      r_state <= S_WAIT_STOP;
                    end
                  end
                  S_ADDR_H: begin
                    r_addr_h <= w_byte;
                    r_state  <= S_ACK_AH;
                  end
                  S_ADDR_L: begin
                    r_ptr   <= {r_addr_h, w_byte};
                    r_state <= S_ACK_AL;
                  end
                  default: begin
                    O_wr_valid <= 1'b1;
                    O_wr_addr  <= r_ptr;
                    O_wr_data  <= w_byte;
                    r_ptr      <= w_ptr_nxt;
                    r_state    <= S_ACK_WD;
                  end
                endcase
              end
            end
          end
          // First SCL fall asserts ACK, the fall after the 9th rise releases it
          S_ACK_DEV, S_ACK_AH, S_ACK_AL, S_ACK_WD: begin
            if (r_scl_rise) begin
              r_ninth <= 1'b1;
            end else if (r_scl_fall) begin
              if (!r_ninth) begin
                O_sda_oe <= 1'b1;
              end else begin
                O_sda_oe <= 1'b0;
                r_bitcnt <= 4'd0;
                case (r_state)
                  S_ACK_DEV: begin
                    if (r_rw) begin
                      r_state  <= S_RDATA;
                      r_rd     <= w_rd_cur[6:0];
                      O_sda_oe <= ~w_rd_cur[7];
                    end else begin
                      r_state <= S_ADDR_H;
                    end
                  end
                  S_ACK_AH: r_state <= S_ADDR_L;
                  default:  r_state <= S_WDATA;
                endcase
              end
            end
          end
          S_RDATA: begin
            if (r_scl_rise) begin
              r_bitcnt <= r_bitcnt + 4'd1;
            end else if (r_scl_fall) begin
              if (r_bitcnt == 4'd8) begin
                O_sda_oe <= 1'b0;
                r_ninth  <= 1'b0;
                r_state  <= S_RACK;
              end else begin
                O_sda_oe <= ~r_rd[6];
                r_rd     <= {r_rd[5:0], 1'b0};
              end
            end
          end
          S_RACK: begin
            if (r_scl_rise) begin
              r_ninth <= 1'b1;
              r_mack  <= r_sda_smp;
            end else if (r_scl_fall && r_ninth) begin
              r_ptr <= w_ptr_nxt;
              if (!r_mack) begin
                r_state  <= S_RDATA;
                r_bitcnt <= 4'd0;
                r_rd     <= w_rd_nxt[6:0];
                O_sda_oe <= ~w_rd_nxt[7];
              end else begin
                r_state  <= S_WAIT_STOP;
                O_sda_oe <= 1'b0;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sccb_slave_responder.sv
`default_nettype none
// ============================================================================
// tb_sccb_slave_responder : bus-master stimulus with a write-strobe scoreboard
// Revision 1.0
// ============================================================================
module tb_sccb_slave_responder;
  localparam int T = 200;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        scl_m = 1'b1;
  logic        sda_m = 1'b1;
  logic        w_sda;
  logic        sda_oe, wr_valid, busy;
  logic [15:0] wr_addr;
  logic [7:0]  wr_data;

  int          n_checks = 0;
  int          n_fail = 0;
  int          n_pushed = 0;
  int          strobes = 0;
  int          oe_cycles = 0;
  int          busy_cycles = 0;
  bit          done = 1'b0;
  logic [23:0] exp_q[$];

  assign w_sda = sda_m & ~sda_oe;

  sccb_slave_responder dut (
    .I_clk(clk), .I_rst(rst), .I_scl(scl_m), .I_sda(w_sda),
    .O_sda_oe(sda_oe), .O_wr_valid(wr_valid), .O_wr_addr(wr_addr),
    .O_wr_data(wr_data), .O_busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    strobes     <= strobes + int'(wr_valid);
    oe_cycles   <= oe_cycles + int'(sda_oe);
    busy_cycles <= busy_cycles + int'(busy);
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_wr(input logic [15:0] a, input logic [7:0] d);
    exp_q.push_back({a, d});
    n_pushed++;
  endtask

  task automatic bus_start();
    if (!scl_m) begin
      sda_m = 1'b1; #T;
      scl_m = 1'b1; #T;
    end
    sda_m = 1'b0; #T;
    scl_m = 1'b0; #T;
  endtask

  task automatic bus_stop();
    sda_m = 1'b0; #T;
    scl_m = 1'b1; #T;
    sda_m = 1'b1; #T;
  endtask

  task automatic send_bit(input logic b);
    sda_m = b; #T;
    scl_m = 1'b1; #T;
    scl_m = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic exp_ack, input string name);
    logic a;
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    sda_m = 1'b1; #T;
    scl_m = 1'b1; #(T/2);
    a = w_sda; #(T/2);
    scl_m = 1'b0;
    chk(name, {31'd0, a}, {31'd0, exp_ack});
  endtask

  task automatic read_byte(input logic [7:0] exp, input logic nack, input string name);
    logic [7:0] v;
    for (int i = 7; i >= 0; i--) begin
      sda_m = 1'b1; #T;
      scl_m = 1'b1; #(T/2);
      v[i] = w_sda; #(T/2);
      scl_m = 1'b0;
    end
    send_bit(nack);
    chk(name, {24'd0, v}, {24'd0, exp});
  endtask

  task automatic wr_hdr(input logic [15:0] a);
    bus_start();
    send_byte(8'h78, 1'b0, "ack_id_w");
    send_byte(a[15:8], 1'b0, "ack_addr_h");
    send_byte(a[7:0], 1'b0, "ack_addr_l");
  endtask

  task automatic rd_hdr();
    bus_start();
    send_byte(8'h79, 1'b0, "ack_id_r");
  endtask

  initial begin
    int s_oe, s_busy, s_str;
    logic [23:0] e;
    fork
      begin
        while (!done) begin
          @(negedge clk);
          if (wr_valid) begin
            if (exp_q.size() == 0) begin
              n_checks++;
              n_fail++;
              $display("FAIL unexpected_strobe: got addr %0h data %0h expected none", wr_addr, wr_data);
            end else begin
              e = exp_q.pop_front();
              chk("wr_addr", {16'd0, wr_addr}, {16'd0, e[23:8]});
              chk("wr_data", {24'd0, wr_data}, {24'd0, e[7:0]});
            end
          end
        end
      end
      begin
        repeat (4) @(posedge clk);
        #1;
        chk("rst_oe", {31'd0, sda_oe}, 32'd0);
        chk("rst_valid", {31'd0, wr_valid}, 32'd0);
        chk("rst_addr", {16'd0, wr_addr}, 32'd0);
        chk("rst_data", {24'd0, wr_data}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        @(negedge clk) rst = 1'b0;
        repeat (10) @(posedge clk);

        // single write
        wr_hdr(16'h3008);
        push_wr(16'h3008, 8'h82);
        send_byte(8'h82, 1'b0, "ack_wd");
        #1 chk("busy_mid", {31'd0, busy}, 32'd1);
        bus_stop();
        chk("busy_after_stop", {31'd0, busy}, 32'd0);
        chk("oe_after_stop", {31'd0, sda_oe}, 32'd0);

        // burst and read-back
        wr_hdr(16'h4740);
        push_wr(16'h4740, 8'h11); send_byte(8'h11, 1'b0, "ack_wd");
        push_wr(16'h4741, 8'h22); send_byte(8'h22, 1'b0, "ack_wd");
        push_wr(16'h4742, 8'h33); send_byte(8'h33, 1'b0, "ack_wd");
        bus_stop();
        wr_hdr(16'h4740);
        bus_stop();
        rd_hdr();
        read_byte(8'h11, 1'b0, "rd_4740");
        read_byte(8'h22, 1'b0, "rd_4741");
        read_byte(8'h33, 1'b1, "rd_4742");
        bus_stop();

        // wrong device ID
        s_oe = oe_cycles; s_busy = busy_cycles; s_str = strobes;
        bus_start();
        send_byte(8'h42, 1'b1, "nack_bad_id");
        send_byte(8'h12, 1'b1, "nack_bad_data");
        bus_stop();
        chk("bad_id_oe", oe_cycles, s_oe);
        chk("bad_id_busy", busy_cycles, s_busy);
        chk("bad_id_strobe", strobes, s_str);

        // pointer wrap
        wr_hdr(16'hFFFF);
        push_wr(16'hFFFF, 8'hAA); send_byte(8'hAA, 1'b0, "ack_wd");
        push_wr(16'h0000, 8'hBB); send_byte(8'hBB, 1'b0, "ack_wd");
        bus_stop();
        wr_hdr(16'hFFFF);
        bus_stop();
        rd_hdr();
        read_byte(8'hAA, 1'b0, "rd_ffff");
        read_byte(8'hBB, 1'b1, "rd_wrap_0000");
        bus_stop();

        // STOP after 4 data bits: discarded, pointer stays at 0x5000
        s_str = strobes;
        wr_hdr(16'h5000);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
        bus_stop();
        chk("abort_oe", {31'd0, sda_oe}, 32'd0);
        chk("abort_strobe", strobes, s_str);
        rd_hdr();
        read_byte(8'hBB, 1'b1, "rd_after_abort");
        bus_stop();

        // repeated START into a read
        wr_hdr(16'h4741);
        rd_hdr();
        read_byte(8'h22, 1'b1, "rd_rep_start");
        bus_stop();

        // reset while ACK is driven
        bus_start();
        for (int i = 7; i >= 0; i--) send_bit(i == 6 || i == 5 || i == 4 || i == 3);
        sda_m = 1'b1;
        for (int i = 0; i < 100 && !sda_oe; i++) @(posedge clk);
        chk("ack_before_rst", {31'd0, sda_oe}, 32'd1);
        @(negedge clk) rst = 1'b1;
        @(posedge clk) #1;
        chk("oe_after_rst", {31'd0, sda_oe}, 32'd0);
        chk("busy_after_rst", {31'd0, busy}, 32'd0);
        @(negedge clk) rst = 1'b0;
        #T scl_m = 1'b1;
        #T scl_m = 1'b0;
        bus_stop();
        wr_hdr(16'h3008);
        bus_stop();
        rd_hdr();
        read_byte(8'h82, 1'b1, "rd_bank_retained");
        bus_stop();
        wr_hdr(16'h3008);
        push_wr(16'h3008, 8'h55); send_byte(8'h55, 1'b0, "ack_wd");
        bus_stop();

        repeat (20) @(posedge clk);
        chk("sb_empty", exp_q.size(), 32'd0);
        chk("strobe_count", strobes, n_pushed);
        done = 1'b1;
      end
    join
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
